// File: rtl/osnt_packet_snapper_pkg.sv
// Shared types for the OSNT packet snapper: FSM state encoding and TUSER length field position.
package osnt_packet_snapper_pkg;

  typedef enum logic [1:0] {
    ST_FIRST = 2'd0,
    ST_PASS  = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  localparam int TUSER_LEN_LO = 0;
  localparam int TUSER_LEN_HI = 15;

  // Beat index stops at all-ones instead of wrapping on very long packets
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

endpackage

// File: rtl/osnt_packet_snapper_if.sv
// AXI4-Stream bundle (tdata/tstrb/tuser/tvalid/tready/tlast) used on both sides of the snapper.
interface osnt_packet_snapper_if #(
  parameter int DW = 256,
  parameter int UW = 128
);
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tstrb;
  logic [UW-1:0]   tuser;
  logic            tvalid;
  logic            tready;
  logic            tlast;

  modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/osnt_packet_snapper_skid_reg.sv
// Two-entry output register: one-cycle latency, full throughput, ready derived only from flops.
module osnt_axis_skid_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);
  logic [W-1:0] out_data_r;
  logic [W-1:0] skid_data_r;
  logic         out_valid_r;
  logic         skid_valid_r;
  logic         pop_s;
  logic         push_s;

  assign pop_s     = out_valid_r && out_ready;
  assign push_s    = in_valid && !skid_valid_r;
  assign in_ready  = !skid_valid_r;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;

  // Output slot refills from the skid slot first so ordering is preserved
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_r   <= '0;
      skid_data_r  <= '0;
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (skid_valid_r) begin
      if (pop_s) begin
        out_data_r   <= skid_data_r;
        skid_valid_r <= 1'b0;
      end
    end else if (push_s) begin
      if (!out_valid_r || pop_s) begin
        out_data_r  <= in_data;
        out_valid_r <= 1'b1;
      end else begin
        skid_data_r  <= in_data;
        skid_valid_r <= 1'b1;
      end
    end else if (pop_s) begin
      out_valid_r <= 1'b0;
    end
  end

endmodule

// File: rtl/osnt_packet_snapper.sv
// Truncates AXI4-Stream packets to a per-packet snap length, masks the last kept word,
// rewrites the TUSER length and counts truncated packets.
module osnt_packet_snapper
  import osnt_packet_snapper_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_CNT_WIDTH        = 32
) (
  input  logic                   axi_aclk,
  input  logic                   axi_reset,
  input  logic                   cfg_cut_en,
  input  logic [15:0]            cfg_cut_bytes,
  osnt_packet_snapper_if.slave   s_axis,
  osnt_packet_snapper_if.master  m_axis,
  output logic [C_CNT_WIDTH-1:0] pkt_cut_count
);
  localparam int          BPW    = C_AXIS_DATA_WIDTH / 8;
  localparam int          SKID_W = C_AXIS_DATA_WIDTH + BPW + C_AXIS_TUSER_WIDTH + 1;
  localparam logic [15:0] BPW_L  = 16'(BPW);

  state_t                        state_r, state_s;
  logic [15:0]                   word_cnt_r, word_cnt_s;
  logic                          cut_act_r, cut_act_s;
  logic [15:0]                   cut_word_r, cut_word_s;
  logic [BPW-1:0]                cut_mask_r, cut_mask_s;
  logic [15:0]                   cut_bytes_r, cut_bytes_s;
  logic                          rewrite_r, rewrite_s;
  logic [C_CNT_WIDTH-1:0]        cut_count_r, cut_count_s;
  logic [15:0]                   bytes_m1_s, cfg_rem_s;
  logic [BPW-1:0]                cfg_mask_s;
  logic                          cfg_act_s, fire_s, at_cut_s, truncate_s, tready_s;
  logic                          skid_in_valid_s, skid_in_ready_s;
  logic [BPW-1:0]                out_strb_s;
  logic [C_AXIS_TUSER_WIDTH-1:0] out_user_s;
  logic                          out_last_s;
  logic [SKID_W-1:0]             skid_out_s;

  assign tready_s        = !axi_reset && ((state_r == ST_DROP) || skid_in_ready_s);
  assign s_axis.tready   = tready_s;
  assign fire_s          = s_axis.tvalid && tready_s;
  assign skid_in_valid_s = fire_s && (state_r != ST_DROP);
  assign pkt_cut_count   = cut_count_r;

  // Live config applies on a first beat; later beats use the values latched with it
  always_comb begin
    bytes_m1_s = cfg_cut_bytes - 16'd1;
    cfg_rem_s  = bytes_m1_s % BPW_L;
    cfg_act_s  = cfg_cut_en && (cfg_cut_bytes != 16'd0);
    for (int i = 0; i < BPW; i++) begin
      cfg_mask_s[i] = (16'(i) <= cfg_rem_s);
    end
    if (state_r == ST_FIRST) begin
      cut_act_s   = cfg_act_s;
      cut_word_s  = bytes_m1_s / BPW_L;
      cut_mask_s  = cfg_mask_s;
      cut_bytes_s = cfg_cut_bytes;
      rewrite_s   = cfg_act_s && (cfg_cut_bytes < s_axis.tuser[TUSER_LEN_HI:TUSER_LEN_LO]);
    end else begin
      cut_act_s   = cut_act_r;
      cut_word_s  = cut_word_r;
      cut_mask_s  = cut_mask_r;
      cut_bytes_s = cut_bytes_r;
      rewrite_s   = rewrite_r;
    end
  end

  // Next-state, beat counter, truncation detection and output beat shaping
  always_comb begin
    state_s     = state_r;
    word_cnt_s  = word_cnt_r;
    cut_count_s = cut_count_r;
    at_cut_s    = cut_act_s && (word_cnt_r == cut_word_s);
    truncate_s  = at_cut_s && (!s_axis.tlast || ((s_axis.tstrb & ~cut_mask_s) != '0));
    out_strb_s  = at_cut_s ? (s_axis.tstrb & cut_mask_s) : s_axis.tstrb;
    out_last_s  = s_axis.tlast || at_cut_s;
    out_user_s  = s_axis.tuser;
    if (rewrite_s) begin
      out_user_s[TUSER_LEN_HI:TUSER_LEN_LO] = cut_bytes_s;
    end else begin
      out_user_s[TUSER_LEN_HI:TUSER_LEN_LO] = s_axis.tuser[TUSER_LEN_HI:TUSER_LEN_LO];
    end
    if (fire_s) begin
      case (state_r)
        ST_FIRST, ST_PASS: begin
          if (s_axis.tlast) begin
            state_s = ST_FIRST;
          end else if (at_cut_s) begin
            state_s = ST_DROP;
          end else begin
            state_s = ST_PASS;
          end
          if (truncate_s) begin
            cut_count_s = cut_count_r + C_CNT_WIDTH'(1);
          end else begin
            cut_count_s = cut_count_r;
          end
        end
        ST_DROP: begin
          state_s = s_axis.tlast ? ST_FIRST : ST_DROP;
        end
        default: begin
          state_s = ST_FIRST;
        end
      endcase
      if (state_s == ST_FIRST) begin
        word_cnt_s = 16'd0;
      end else begin
        word_cnt_s = sat_inc16(word_cnt_r);
      end
    end else begin
      state_s = state_r;
    end
  end

  // State, per-packet config latch and truncation counter
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state_r     <= ST_FIRST;
      word_cnt_r  <= 16'd0;
      cut_act_r   <= 1'b0;
      cut_word_r  <= 16'd0;
      cut_mask_r  <= '0;
      cut_bytes_r <= 16'd0;
      rewrite_r   <= 1'b0;
      cut_count_r <= '0;
    end else begin
      state_r     <= state_s;
      word_cnt_r  <= word_cnt_s;
      cut_count_r <= cut_count_s;
      if (fire_s && (state_r == ST_FIRST)) begin
        cut_act_r   <= cut_act_s;
        cut_word_r  <= cut_word_s;
        cut_mask_r  <= cut_mask_s;
        cut_bytes_r <= cut_bytes_s;
        rewrite_r   <= rewrite_s;
      end
    end
  end

  osnt_axis_skid_reg #(
    .W (SKID_W)
  ) u_skid (
    .clk       (axi_aclk),
    .reset     (axi_reset),
    .in_data   ({s_axis.tdata, out_strb_s, out_user_s, out_last_s}),
    .in_valid  (skid_in_valid_s),
    .in_ready  (skid_in_ready_s),
    .out_data  (skid_out_s),
    .out_valid (m_axis.tvalid),
    .out_ready (m_axis.tready)
  );

  assign {m_axis.tdata, m_axis.tstrb, m_axis.tuser, m_axis.tlast} = skid_out_s;

endmodule

// File: tb/tb_osnt_packet_snapper.sv
// Directed bench for osnt_packet_snapper: scoreboard of hand-specified expected beats per packet.
module tb_osnt_packet_snapper;
  logic        axi_aclk = 1'b0;
  logic        axi_reset;
  logic        cfg_cut_en;
  logic [15:0] cfg_cut_bytes;
  logic [31:0] pkt_cut_count;
  logic        rand_en = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;

  logic [255:0] ex_d[$], rx_d[$];
  logic [31:0]  ex_s[$], rx_s[$];
  logic [127:0] ex_u[$], rx_u[$];
  logic         ex_l[$], rx_l[$];

  osnt_packet_snapper_if #(.DW(256), .UW(128)) s_axis ();
  osnt_packet_snapper_if #(.DW(256), .UW(128)) m_axis ();

  osnt_packet_snapper #(
    .C_AXIS_DATA_WIDTH (256),
    .C_AXIS_TUSER_WIDTH(128),
    .C_CNT_WIDTH       (32)
  ) dut (
    .axi_aclk     (axi_aclk),
    .axi_reset    (axi_reset),
    .cfg_cut_en   (cfg_cut_en),
    .cfg_cut_bytes(cfg_cut_bytes),
    .s_axis       (s_axis),
    .m_axis       (m_axis),
    .pkt_cut_count(pkt_cut_count)
  );

  always #5 axi_aclk = ~axi_aclk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [255:0] pat(input int p, input int w);
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = {8'(p), 8'(w), 8'(i), 8'hA5};
    return v;
  endfunction

  function automatic logic [127:0] usr(input int p, input logic [15:0] len);
    return {{7{16'(p)}}, len};
  endfunction

  function automatic logic [31:0] in_strb(input int w, input int nin, input int len);
    logic [31:0] m;
    int r;
    m = 32'hFFFF_FFFF;
    if (w == nin - 1) begin
      r = ((len - 1) % 32) + 1;
      m = 32'd0;
      for (int i = 0; i < r; i++) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Expected output: nout beats, last one carrying last_strb and tlast, all with len_out
  task automatic push_exp(input int p, input int nout, input logic [31:0] last_strb,
                          input logic [15:0] len_out, input int nin, input int len_in);
    for (int i = 0; i < nout; i++) begin
      ex_d.push_back(pat(p, i));
      ex_s.push_back((i == nout - 1) ? last_strb : in_strb(i, nin, len_in));
      ex_u.push_back(usr(p, len_out));
      ex_l.push_back(i == nout - 1);
    end
  endtask

  task automatic send_word(input int p, input int w, input int nin, input int len,
                           input bit count_stall, inout int stalls);
    int waited;
    bit acc;
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = pat(p, w);
    s_axis.tstrb  = in_strb(w, nin, len);
    s_axis.tuser  = usr(p, 16'(len));
    s_axis.tlast  = (w == nin - 1);
    waited = 0;
    acc = 1'b0;
    while (!acc && waited < 200) begin
      @(negedge axi_aclk);
      if (s_axis.tready) acc = 1'b1;
      else begin
        waited++;
        if (count_stall) stalls++;
      end
      @(posedge axi_aclk);
      #1;
    end
    if (!acc) chk("accept_timeout", 256'(waited), 256'(0));
  endtask

  task automatic send_pkt(input int p, input int nin, input int len, input int chg_word,
                          input logic [15:0] chg_val, input int drop_from, output int stalls);
    stalls = 0;
    for (int w = 0; w < nin; w++) begin
      send_word(p, w, nin, len, (drop_from >= 0) && (w >= drop_from), stalls);
      if (w == chg_word) cfg_cut_bytes = chg_val;
    end
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
  endtask

  task automatic clear_q();
    ex_d.delete(); ex_s.delete(); ex_u.delete(); ex_l.delete();
    rx_d.delete(); rx_s.delete(); rx_u.delete(); rx_l.delete();
  endtask

  task automatic verify(input string tag, input int exp_cnt);
    int t;
    int n;
    t = 0;
    while (rx_d.size() < ex_d.size() && t < 500) begin
      @(posedge axi_aclk);
      t++;
    end
    repeat (4) @(posedge axi_aclk);
    #1;
    chk({tag, "_nbeats"}, 256'(rx_d.size()), 256'(ex_d.size()));
    n = (rx_d.size() < ex_d.size()) ? rx_d.size() : ex_d.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_data%0d", tag, i), rx_d[i], ex_d[i]);
      chk($sformatf("%s_strb%0d", tag, i), 256'(rx_s[i]), 256'(ex_s[i]));
      chk($sformatf("%s_user%0d", tag, i), 256'(rx_u[i]), 256'(ex_u[i]));
      chk($sformatf("%s_last%0d", tag, i), 256'(rx_l[i]), 256'(ex_l[i]));
    end
    chk({tag, "_count"}, 256'(pkt_cut_count), 256'(exp_cnt));
    clear_q();
  endtask

  // Output monitor: a beat transfers when valid and ready are both high at the next edge
  initial forever begin
    @(negedge axi_aclk);
    if (!axi_reset && m_axis.tvalid && m_axis.tready) begin
      rx_d.push_back(m_axis.tdata);
      rx_s.push_back(m_axis.tstrb);
      rx_u.push_back(m_axis.tuser);
      rx_l.push_back(m_axis.tlast);
    end
  end

  initial forever begin
    @(posedge axi_aclk);
    #1;
    m_axis.tready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    axi_reset     = 1'b1;
    cfg_cut_en    = 1'b0;
    cfg_cut_bytes = 16'd0;
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    s_axis.tstrb  = '0;
    s_axis.tuser  = '0;
    s_axis.tlast  = 1'b0;
    m_axis.tready = 1'b1;
    repeat (2) @(posedge axi_aclk);
    #1;
    chk("rst_tready", 256'(s_axis.tready), 256'(0));
    chk("rst_tvalid", 256'(m_axis.tvalid), 256'(0));
    chk("rst_count", 256'(pkt_cut_count), 256'(0));
    axi_reset = 1'b0;
    @(posedge axi_aclk);
    #1;

    // 1: truncation disabled, 3 words of 80 bytes pass untouched
    cfg_cut_en = 1'b0; cfg_cut_bytes = 16'd63;
    push_exp(1, 3, 32'h0000_FFFF, 16'd80, 3, 80);
    send_pkt(1, 3, 80, -1, 16'd0, -1, st);
    verify("t1", 0);

    // 2: snap 63 bytes of a 128-byte packet
    cfg_cut_en = 1'b1; cfg_cut_bytes = 16'd63;
    push_exp(2, 2, 32'h7FFF_FFFF, 16'd63, 4, 128);
    send_pkt(2, 4, 128, -1, 16'd0, -1, st);
    verify("t2", 1);

    // 3: snap exactly at packet length, then truncation by one extra word
    cfg_cut_bytes = 16'd64;
    push_exp(3, 2, 32'hFFFF_FFFF, 16'd64, 2, 64);
    send_pkt(3, 2, 64, -1, 16'd0, -1, st);
    verify("t3a", 1);
    push_exp(4, 2, 32'hFFFF_FFFF, 16'd64, 3, 70);
    send_pkt(4, 3, 70, -1, 16'd0, -1, st);
    verify("t3b", 2);

    // 4: back-to-back packets with random output backpressure
    cfg_cut_bytes = 16'd40;
    rand_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push_exp(10 + k, 2, 32'h0000_00FF, 16'd40, 5, 160);
      send_pkt(10 + k, 5, 160, -1, 16'd0, 2, st);
      chk($sformatf("t4_drop_stall%0d", k), 256'(st), 256'(0));
    end
    verify("t4", 6);
    rand_en = 1'b0;

    // 5: config change mid-packet only affects the following packet
    cfg_cut_bytes = 16'd63;
    push_exp(20, 2, 32'h7FFF_FFFF, 16'd63, 4, 128);
    send_pkt(20, 4, 128, 0, 16'd200, -1, st);
    push_exp(21, 7, 32'h0000_00FF, 16'd200, 8, 256);
    send_pkt(21, 8, 256, -1, 16'd0, -1, st);
    verify("t5", 8);

    // 6: reset while word 2 of a packet is offered
    cfg_cut_bytes = 16'd63;
    st = 0;
    send_word(30, 0, 4, 128, 1'b0, st);
    send_word(30, 1, 4, 128, 1'b0, st);
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = pat(30, 2);
    s_axis.tlast  = 1'b0;
    axi_reset = 1'b1;
    @(posedge axi_aclk);
    #1;
    chk("t6_tvalid", 256'(m_axis.tvalid), 256'(0));
    chk("t6_tdata", m_axis.tdata, 256'(0));
    chk("t6_tstrb", 256'(m_axis.tstrb), 256'(0));
    chk("t6_tuser", 256'(m_axis.tuser), 256'(0));
    chk("t6_tlast", 256'(m_axis.tlast), 256'(0));
    chk("t6_count", 256'(pkt_cut_count), 256'(0));
    chk("t6_tready", 256'(s_axis.tready), 256'(0));
    axi_reset = 1'b0;
    s_axis.tvalid = 1'b0;
    clear_q();
    repeat (2) @(posedge axi_aclk);
    #1;
    push_exp(31, 2, 32'h7FFF_FFFF, 16'd63, 4, 128);
    send_pkt(31, 4, 128, -1, 16'd0, -1, st);
    verify("t6", 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
